// File: rtl/fifo_level_pkg.sv
// Shared types and defaults for the fifo_level FIFO: error-flag struct, depth helper
// and default widths.
package fifo_level_pkg;

    localparam int DW_DEF = 8;
    localparam int AW_DEF = 4;

    typedef struct packed {
        logic overflow;
        logic underflow;
    } fifo_err_t;

    function automatic int depth(input int aw);
        return 1 << aw;
    endfunction

endpackage

// File: rtl/fifo_level_ctrl.sv
// Control path of fifo_level: acceptance, pointers, occupancy count, level flags and
// the sticky overflow/underflow error registers.
module fifo_level_ctrl
    import fifo_level_pkg::*;
#(
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rd,
    input  logic          wr,
    input  logic [AW:0]   af_th,
    input  logic [AW:0]   ae_th,
    input  logic          clr_err,
    output logic          wr_acc,
    output logic          rd_acc,
    output logic [AW-1:0] w_ptr,
    output logic [AW-1:0] r_ptr,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          full,
    output logic          almost_full,
    output logic          almost_empty,
    output fifo_err_t     err
);

    localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

    logic [AW-1:0] w_ptr_q, w_ptr_d;
    logic [AW-1:0] r_ptr_q, r_ptr_d;
    logic [AW:0]   count_q, count_d;
    fifo_err_t     err_q, err_d;

    assign empty        = (count_q == '0);
    assign full         = (count_q == FULL_CNT);
    assign almost_full  = (count_q >= af_th);
    assign almost_empty = (count_q <= ae_th);

    // A simultaneous read frees the slot the write needs, so a full FIFO still accepts.
    assign rd_acc = rd & ~empty;
    assign wr_acc = wr & (~full | rd);

    always_comb begin
        w_ptr_d = w_ptr_q;
        r_ptr_d = r_ptr_q;
        count_d = count_q;
        if (wr_acc) w_ptr_d = w_ptr_q + 1'b1;
        if (rd_acc) r_ptr_d = r_ptr_q + 1'b1;
        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Set events take priority over clr_err so no error is lost in the clearing cycle.
    always_comb begin
        err_d.overflow  = (wr & ~wr_acc) | (err_q.overflow  & ~clr_err);
        err_d.underflow = (rd & empty)   | (err_q.underflow & ~clr_err);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            count_q <= '0;
            err_q   <= '0;
        end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign w_ptr = w_ptr_q;
    assign r_ptr = r_ptr_q;
    assign count = count_q;
    assign err   = err_q;

endmodule

// File: rtl/fifo_level.sv
// Synchronous FIFO with occupancy count, threshold flags and sticky error flags.
// Define FIFO_LEVEL_REG_OUT_EN for a registered r_data; default is show-ahead.
module fifo_level
    import fifo_level_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rd,
    input  logic          wr,
    input  logic [DW-1:0] w_data,
    input  logic [AW:0]   af_th,
    input  logic [AW:0]   ae_th,
    input  logic          clr_err,
    output logic [DW-1:0] r_data,
    output logic          empty,
    output logic          full,
    output logic          almost_full,
    output logic          almost_empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          underflow
);

    logic          wr_acc;
    logic          rd_acc;
    logic [AW-1:0] w_ptr;
    logic [AW-1:0] r_ptr;
    fifo_err_t     err;

    logic [DW-1:0] mem [depth(AW)];

    fifo_level_ctrl #(.AW(AW)) u_ctrl (
        .clk          (clk),
        .reset        (reset),
        .rd           (rd),
        .wr           (wr),
        .af_th        (af_th),
        .ae_th        (ae_th),
        .clr_err      (clr_err),
        .wr_acc       (wr_acc),
        .rd_acc       (rd_acc),
        .w_ptr        (w_ptr),
        .r_ptr        (r_ptr),
        .count        (count),
        .empty        (empty),
        .full         (full),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .err          (err)
    );

    assign overflow  = err.overflow;
    assign underflow = err.underflow;

    // Storage is not reset; only the pointers define valid contents.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[w_ptr] <= w_data;
    end

`ifdef FIFO_LEVEL_REG_OUT_EN
    logic [DW-1:0] r_data_q, r_data_d;

    always_comb begin
        r_data_d = r_data_q;
        if (rd_acc) r_data_d = mem[r_ptr];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_data_q <= '0;
        else        r_data_q <= r_data_d;
    end

    assign r_data = r_data_q;
`else
    assign r_data = mem[r_ptr];
`endif

endmodule

// File: tb/tb_fifo_level.sv
// Directed self-checking bench for fifo_level (AW=4, DW=8), in either r_data mode.
module tb_fifo_level;

    logic       clk = 1'b0;
    logic       reset;
    logic       rd, wr, clr_err;
    logic [7:0] w_data;
    logic [4:0] af_th, ae_th;
    logic [7:0] r_data;
    logic       empty, full, almost_full, almost_empty;
    logic [4:0] count;
    logic       overflow, underflow;

    int checks = 0;
    int errors = 0;

    fifo_level #(.DW(8), .AW(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .rd           (rd),
        .wr           (wr),
        .w_data       (w_data),
        .af_th        (af_th),
        .ae_th        (ae_th),
        .clr_err      (clr_err),
        .r_data       (r_data),
        .empty        (empty),
        .full         (full),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp_d;
        reset   = 1'b1;
        rd      = 1'b0;
        wr      = 1'b0;
        clr_err = 1'b0;
        w_data  = 8'h00;
        af_th   = 5'd0;
        ae_th   = 5'd3;
        #2 reset = 1'b0;
        tick();
        tick();

        check_eq("rst_count", count, 0);
        check_eq("rst_empty", empty, 1);
        check_eq("rst_full", full, 0);
        check_eq("rst_ae", almost_empty, 1);
        check_eq("rst_af_th0", almost_full, 1);
        check_eq("rst_ovf", overflow, 0);
        check_eq("rst_unf", underflow, 0);
`ifdef FIFO_LEVEL_REG_OUT_EN
        check_eq("rst_rdata", r_data, 0);
`endif
        af_th = 5'd12;
        #1 check_eq("af_th12_empty", almost_full, 0);
        reset = 1'b1;
        tick();

        // Fill with 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            wr = 1'b1;
            w_data = 8'(i);
            tick();
            check_eq("fill_count", count, 32'(i + 1));
            if (i + 1 == 11) check_eq("af_at11", almost_full, 0);
            if (i + 1 == 12) check_eq("af_at12", almost_full, 1);
        end
        check_eq("full_flag", full, 1);
        check_eq("full_ovf_clear", overflow, 0);

        w_data = 8'hEE;
        tick();
        check_eq("ovf_set", overflow, 1);
        check_eq("ovf_count", count, 16);

        // Write-through while full
        rd = 1'b1;
        w_data = 8'hAA;
`ifndef FIFO_LEVEL_REG_OUT_EN
        check_eq("head_before_wt", r_data, 8'h00);
`endif
        tick();
        check_eq("wt_count", count, 16);
        check_eq("wt_full", full, 1);
`ifdef FIFO_LEVEL_REG_OUT_EN
        check_eq("wt_pop_data", r_data, 8'h00);
`endif
        wr = 1'b0;
        rd = 1'b0;

        // Drain across the pointer wrap: 0x01..0x0F then 0xAA
        for (int k = 0; k < 16; k++) begin
            exp_d = (k < 15) ? 8'(k + 1) : 8'hAA;
`ifndef FIFO_LEVEL_REG_OUT_EN
            check_eq("drain_data", r_data, exp_d);
`endif
            rd = 1'b1;
            tick();
`ifdef FIFO_LEVEL_REG_OUT_EN
            check_eq("drain_data", r_data, exp_d);
`endif
            check_eq("drain_count", count, 32'(15 - k));
            if (15 - k == 4) check_eq("ae_at4", almost_empty, 0);
            if (15 - k == 3) check_eq("ae_at3", almost_empty, 1);
        end
        check_eq("drained_empty", empty, 1);
        check_eq("drained_unf", underflow, 0);

        // Underflow and clearing
        tick();
        check_eq("unf_set", underflow, 1);
        check_eq("unf_count", count, 0);
        rd = 1'b0;
        clr_err = 1'b1;
        tick();
        check_eq("unf_clr", underflow, 0);
        check_eq("ovf_clr", overflow, 0);
        rd = 1'b1;
        tick();
        check_eq("unf_set_wins", underflow, 1);
        rd = 1'b0;
        tick();
        clr_err = 1'b0;
        check_eq("unf_clr2", underflow, 0);

        // Empty with rd & wr: only the write goes in
        rd = 1'b1;
        wr = 1'b1;
        w_data = 8'h5A;
        tick();
        rd = 1'b0;
        wr = 1'b0;
        check_eq("erw_count", count, 1);
        check_eq("erw_unf", underflow, 1);
        check_eq("erw_empty", empty, 0);
`ifndef FIFO_LEVEL_REG_OUT_EN
        check_eq("showahead_5a", r_data, 8'h5A);
`endif
        rd = 1'b1;
        tick();
        rd = 1'b0;
        check_eq("pop5a_count", count, 0);
`ifdef FIFO_LEVEL_REG_OUT_EN
        check_eq("regout_5a", r_data, 8'h5A);
        tick();
        check_eq("regout_hold", r_data, 8'h5A);
`endif

        // Reset mid-stream at count 7
        for (int i = 0; i < 7; i++) begin
            wr = 1'b1;
            w_data = 8'(8'h30 + i);
            tick();
        end
        wr = 1'b0;
        check_eq("pre_rst_count", count, 7);
        check_eq("pre_rst_unf", underflow, 1);
        wr = 1'b1;
        #2 reset = 1'b0;
        #1;
        check_eq("async_rst_count", count, 0);
        check_eq("async_rst_empty", empty, 1);
        check_eq("async_rst_unf", underflow, 0);
`ifdef FIFO_LEVEL_REG_OUT_EN
        check_eq("async_rst_rdata", r_data, 0);
`endif
        wr = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        check_eq("post_rst_count", count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
